// File: rtl/register_file_mp_pkg.sv
// Shared types and defaults for the multi-port register file with busy scoreboard.
package PkgRegFileMp;

  typedef enum logic {RF_CLEAR, RF_RUN} RfState;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_NUM_WR   = 2;

  function automatic int sel_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy bits: reset clears all, a claim sets, a release clears; claim beats release.
module register_file_mp_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_claim_en,
  input  logic [SEL_W-1:0]    i_claim_sel,
  input  logic [NUM_REGS-1:0] i_release,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_claim_en && (i_claim_sel == SEL_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (i_release[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
      // Register 0 is never busy; this later assignment overrides anything above.
      r_busy[0] <= 1'b0;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file (async reads, sync writes, r0 = 0) with busy scoreboard and clear sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_mp
  import PkgRegFileMp::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_RD   = DEF_NUM_RD,
  parameter  int NUM_WR   = DEF_NUM_WR,
  localparam int SEL_W    = sel_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*SEL_W-1:0]  wr_sel,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     claim_en,
  input  logic [SEL_W-1:0]         claim_sel,
  output logic                     ready
);

  RfState              r_state;
  RfState              w_state_nxt;
  logic [SEL_W-1:0]    r_clr_idx;
  logic                r_ready;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                w_run;
  logic                w_claim_en;
  logic [NUM_REGS-1:0] w_release;
  logic [NUM_REGS-1:0] w_busy;

  assign w_run = (r_state == RF_RUN);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RF_CLEAR: if (r_clr_idx == SEL_W'(NUM_REGS - 1)) w_state_nxt = RF_RUN;
      default:  w_state_nxt = RF_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= SEL_W'(1);
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == RF_RUN);
      if (r_state == RF_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  // NOTE: the array has no reset branch; the clear sequencer zeroes it after reset,
  // which keeps it mappable onto plain storage. Later loop iterations win, so the
  // highest-index write port takes priority on a collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == RF_CLEAR) begin
        r_regs[r_clr_idx] <= '0;
      end else begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && (wr_sel[p*SEL_W +: SEL_W] != '0)) begin
            r_regs[wr_sel[p*SEL_W +: SEL_W]] <= wr_data[p*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_comb begin
    w_release = '0;
    if (w_run) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p]) w_release[wr_sel[p*SEL_W +: SEL_W]] = 1'b1;
      end
    end
  end

  assign w_claim_en = w_run && claim_en && (claim_sel != '0);

  register_file_mp_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_claim_en  (w_claim_en),
    .i_claim_sel (claim_sel),
    .i_release   (w_release),
    .o_busy      (w_busy)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_sel[r*SEL_W +: SEL_W] != '0) begin
        rd_data[r*DATA_W +: DATA_W] = r_regs[rd_sel[r*SEL_W +: SEL_W]];
        rd_busy[r]                  = w_busy[rd_sel[r*SEL_W +: SEL_W]];
`ifdef REGFILE_BYPASS_EN
        if (w_run) begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_sel[p*SEL_W +: SEL_W] == rd_sel[r*SEL_W +: SEL_W])) begin
              rd_data[r*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
              // A same-cycle claim on this register will leave it busy, so report that.
              rd_busy[r] = claim_en && (claim_sel == rd_sel[r*SEL_W +: SEL_W]);
            end
          end
        end
`endif
      end
    end
  end

  assign ready = r_ready;

endmodule
